// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the flag-rich synchronous FIFO: pointer sizing, parameter
// legality checks, read-mode constants and the status-flag bundle.
package sync_fifo_pkg;

  localparam int unsigned FWFT_OFF = 0;
  localparam int unsigned FWFT_ON  = 1;

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

  // One extra bit over the index width serves as the wrap bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit depth_legal(input int unsigned depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic bit af_legal(input int unsigned level, input int unsigned depth);
    return (level >= 1) && (level <= depth);
  endfunction

  function automatic bit ae_legal(input int unsigned level, input int unsigned depth);
    return level < depth;
  endfunction

  function automatic bit mode_legal(input int unsigned fwft);
    return (fwft == FWFT_OFF) || (fwft == FWFT_ON);
  endfunction

endpackage

// File: rtl/fifo_ram_1r1w.sv
// Storage array for the FIFO: synchronous write, asynchronous read. Kept separate so a
// vendor RAM macro can replace it without touching pointer or flag logic.
module fifo_ram_1r1w #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  // Contents are deliberately not reset; stale words are unreachable via the pointers.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds, occupancy
// count, overflow/underflow pulses, write-while-full-with-read, and optional FWFT reads.
module sync_fifo_flags
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned AF_LEVEL   = FIFO_DEPTH - 2,
  parameter int unsigned AE_LEVEL   = 1,
  parameter int unsigned FWFT       = FWFT_OFF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cs,
  input  logic                        wr_en,
  input  logic                        rd_en,
  input  logic [DATA_WIDTH-1:0]       data_in,
  output logic [DATA_WIDTH-1:0]       data_out,
  output logic                        data_valid,
  output logic                        empty,
  output logic                        full,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int unsigned PtrW = ptr_width(FIFO_DEPTH);
  localparam int unsigned IdxW = PtrW - 1;

  if (!depth_legal(FIFO_DEPTH)) begin : g_bad_depth
    $fatal(1, "sync_fifo_flags: FIFO_DEPTH must be a power of two and at least 2");
  end
  if (!af_legal(AF_LEVEL, FIFO_DEPTH)) begin : g_bad_af
    $fatal(1, "sync_fifo_flags: AF_LEVEL must lie in 1..FIFO_DEPTH");
  end
  if (!ae_legal(AE_LEVEL, FIFO_DEPTH)) begin : g_bad_ae
    $fatal(1, "sync_fifo_flags: AE_LEVEL must lie in 0..FIFO_DEPTH-1");
  end
  if (!mode_legal(FWFT)) begin : g_bad_mode
    $fatal(1, "sync_fifo_flags: FWFT must be 0 or 1");
  end

  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [IdxW-1:0]       wr_idx, rd_idx;
  logic [PtrW-1:0]       occupancy;
  fifo_flags_t           flags;
  logic                  rd_acc, wr_acc;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  overflow_q, underflow_q;

  assign wr_idx = wr_ptr_q[IdxW-1:0];
  assign rd_idx = rd_ptr_q[IdxW-1:0];

  // Status is a pure function of the registered pointers.
  always_comb begin
    occupancy          = wr_ptr_q - rd_ptr_q;
    flags.empty        = (wr_ptr_q == rd_ptr_q);
    flags.full         = (wr_idx == rd_idx) && (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]);
    flags.almost_full  = (occupancy >= PtrW'(AF_LEVEL));
    flags.almost_empty = (occupancy <= PtrW'(AE_LEVEL));
  end

  // A read frees a slot in the same cycle, so a full FIFO still takes a paired write.
  assign rd_acc = cs & rd_en & ~flags.empty;
  assign wr_acc = cs & wr_en & (~flags.full | rd_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= cs & wr_en & ~wr_acc;
      underflow_q <= cs & rd_en & ~rd_acc;
    end
  end

  // Requests coinciding with reset must not disturb the array either.
  assign ram_we = wr_acc & rst_n;

  fifo_ram_1r1w #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH),
    .ADDR_W     (IdxW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_idx),
    .wdata (data_in),
    .raddr (rd_idx),
    .rdata (ram_rdata)
  );

  if (FWFT == FWFT_ON) begin : g_fwft
    assign data_out   = ram_rdata;
    assign data_valid = ~flags.empty;
  end else begin : g_reg_out
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        if (rd_acc) begin
          data_q <= ram_rdata;
        end
        valid_q <= rd_acc;
      end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
  end

  assign empty        = flags.empty;
  assign full         = flags.full;
  assign almost_full  = flags.almost_full;
  assign almost_empty = flags.almost_empty;
  assign count        = occupancy;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Self-checking bench for sync_fifo_flags: registered-read instance driven against a
// queue-based scoreboard, plus an FWFT instance for the fall-through behaviour.
module tb_sync_fifo_flags;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, cs, wr_en, rd_en;
  logic [DW-1:0] data_in, data_out;
  logic          data_valid, empty, full, almost_full, almost_empty, overflow, underflow;
  logic [3:0]    count;

  logic          f_cs, f_wr, f_rd;
  logic [DW-1:0] f_din, f_dout;
  logic          f_dv, f_empty, f_full, f_af, f_ae, f_ovf, f_unf;
  logic [3:0]    f_count;

  sync_fifo_flags #(
    .DATA_WIDTH (DW), .FIFO_DEPTH (DEPTH), .AF_LEVEL (AF), .AE_LEVEL (AE), .FWFT (0)
  ) u_dut (
    .clk (clk), .rst_n (rst_n), .cs (cs), .wr_en (wr_en), .rd_en (rd_en),
    .data_in (data_in), .data_out (data_out), .data_valid (data_valid), .empty (empty),
    .full (full), .almost_full (almost_full), .almost_empty (almost_empty), .count (count),
    .overflow (overflow), .underflow (underflow)
  );

  sync_fifo_flags #(
    .DATA_WIDTH (DW), .FIFO_DEPTH (DEPTH), .AF_LEVEL (AF), .AE_LEVEL (AE), .FWFT (1)
  ) u_fwft (
    .clk (clk), .rst_n (rst_n), .cs (f_cs), .wr_en (f_wr), .rd_en (f_rd),
    .data_in (f_din), .data_out (f_dout), .data_valid (f_dv), .empty (f_empty),
    .full (f_full), .almost_full (f_af), .almost_empty (f_ae), .count (f_count),
    .overflow (f_ovf), .underflow (f_unf)
  );

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] sb[$];
  int            m_count;
  bit            m_ovf, m_unf, m_dv;
  logic [DW-1:0] m_exp, m_last;

  // Drive one cycle on the registered-read instance and advance the reference model.
  task automatic drive(input bit c, input bit w, input bit r, input logic [DW-1:0] d);
    bit ra, wa;
    cs = c; wr_en = w; rd_en = r; data_in = d;
    ra = c && r && (m_count > 0);
    wa = c && w && ((m_count < DEPTH) || ra);
    if (wa) sb.push_back(d);
    @(posedge clk); #1;
    m_count = m_count + int'(wa) - int'(ra);
    m_ovf = c && w && !wa;
    m_unf = c && r && !ra;
    m_dv  = ra;
    if (ra) begin
      m_exp  = sb.pop_front();
      m_last = m_exp;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cs = 1'b1; wr_en = 1'b1; rd_en = 1'b1; data_in = 8'hEE;
    f_cs = 1'b1; f_wr = 1'b0; f_rd = 1'b0; f_din = 8'h00;
    @(posedge clk); #1;
    rst_n = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    sb.delete();
    m_count = 0; m_ovf = 0; m_unf = 0; m_dv = 0; m_last = '0; m_exp = '0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", empty); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", full); end
    n_checks++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_af got %b want 0", almost_full); end
    n_checks++; if (almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_ae got %b want 1", almost_empty); end
    n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_dout got %h want 00", data_out); end
    n_checks++; if ({data_valid, overflow, underflow} !== 3'b000) begin
      n_fail++; $display("FAIL reset_pulses got %b want 000", {data_valid, overflow, underflow});
    end
    n_checks++; if (f_empty !== 1'b1 || f_dv !== 1'b0) begin
      n_fail++; $display("FAIL reset_fwft empty/dv got %b%b want 10", f_empty, f_dv);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 1, 0, 8'h10 + 8'(i));
      n_checks++; if (count !== 4'(m_count)) begin n_fail++; $display("FAIL fill_count i=%0d got %0d want %0d", i, count, m_count); end
      n_checks++; if (almost_empty !== (m_count <= AE)) begin n_fail++; $display("FAIL fill_ae i=%0d got %b want %b", i, almost_empty, m_count <= AE); end
      n_checks++; if (almost_full !== (m_count >= AF)) begin n_fail++; $display("FAIL fill_af i=%0d got %b want %b", i, almost_full, m_count >= AF); end
      n_checks++; if (full !== (m_count == DEPTH)) begin n_fail++; $display("FAIL fill_full i=%0d got %b want %b", i, full, m_count == DEPTH); end
    end
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 0, 1, 8'h00);
      n_checks++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL drain_dv i=%0d got %b want 1", i, data_valid); end
      n_checks++; if (data_out !== m_exp) begin n_fail++; $display("FAIL drain_data i=%0d got %h want %h", i, data_out, m_exp); end
    end
    drive(1, 0, 0, 8'h00);
    n_checks++; if (data_valid !== 1'b0 || empty !== 1'b1) begin
      n_fail++; $display("FAIL drain_end dv/empty got %b%b want 01", data_valid, empty);
    end
  endtask

  task automatic test_overflow_underflow();
    for (int i = 0; i < DEPTH; i++) drive(1, 1, 0, 8'h80 + 8'(i));
    drive(1, 1, 0, 8'hEE);
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_pulse got %b want 1", overflow); end
    n_checks++; if (count !== 4'(m_count)) begin n_fail++; $display("FAIL ovf_count got %0d want %0d", count, m_count); end
    drive(1, 0, 0, 8'h00);
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_one_cycle got %b want 0", overflow); end
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 0, 1, 8'h00);
      n_checks++; if (data_out !== m_exp) begin n_fail++; $display("FAIL ovf_drain i=%0d got %h want %h", i, data_out, m_exp); end
    end
    drive(1, 0, 1, 8'h00);
    n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL unf_pulse got %b want 1", underflow); end
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL unf_dv got %b want 0", data_valid); end
    n_checks++; if (data_out !== m_last) begin n_fail++; $display("FAIL unf_dout_held got %h want %h", data_out, m_last); end
    drive(1, 0, 0, 8'h00);
    n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL unf_one_cycle got %b want 0", underflow); end
  endtask

  task automatic test_simul_full();
    for (int i = 0; i < DEPTH; i++) drive(1, 1, 0, 8'h20 + 8'(i));
    drive(1, 1, 1, 8'hAA);
    n_checks++; if (count !== 4'd8 || full !== 1'b1) begin n_fail++; $display("FAIL simul_count got %0d/%b want 8/1", count, full); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL simul_ovf got %b want 0", overflow); end
    n_checks++; if (data_out !== m_exp || data_valid !== 1'b1) begin
      n_fail++; $display("FAIL simul_head got %h/%b want %h/1", data_out, data_valid, m_exp);
    end
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 0, 1, 8'h00);
      n_checks++; if (data_out !== m_exp) begin n_fail++; $display("FAIL simul_drain i=%0d got %h want %h", i, data_out, m_exp); end
    end
    n_checks++; if (data_out !== 8'hAA) begin n_fail++; $display("FAIL simul_last got %h want aa", data_out); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) drive(1, 1, 0, 8'h30 + 8'(i));
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, 1, 8'h40 + 8'(i));
      n_checks++; if (count !== 4'd3) begin n_fail++; $display("FAIL wrap_count i=%0d got %0d want 3", i, count); end
      n_checks++; if (data_out !== m_exp || data_valid !== 1'b1) begin
        n_fail++; $display("FAIL wrap_data i=%0d got %h/%b want %h/1", i, data_out, data_valid, m_exp);
      end
      n_checks++; if ({overflow, underflow} !== 2'b00) begin n_fail++; $display("FAIL wrap_err i=%0d got %b want 00", i, {overflow, underflow}); end
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 8'h00);
      n_checks++; if (data_out !== m_exp) begin n_fail++; $display("FAIL wrap_drain i=%0d got %h want %h", i, data_out, m_exp); end
    end
  endtask

  task automatic test_fwft();
    f_cs = 1'b1; f_wr = 1'b1; f_rd = 1'b0; f_din = 8'h5A;
    @(posedge clk); #1;
    f_wr = 1'b0;
    n_checks++; if (f_dout !== 8'h5A || f_dv !== 1'b1) begin n_fail++; $display("FAIL fwft_show got %h/%b want 5a/1", f_dout, f_dv); end
    f_rd = 1'b1;
    @(posedge clk); #1;
    f_rd = 1'b0;
    n_checks++; if (f_empty !== 1'b1 || f_dv !== 1'b0) begin n_fail++; $display("FAIL fwft_pop got %b/%b want 1/0", f_empty, f_dv); end
    f_wr = 1'b1; f_din = 8'h11;
    @(posedge clk); #1;
    f_din = 8'h22;
    @(posedge clk); #1;
    f_wr = 1'b0; f_rd = 1'b1;
    n_checks++; if (f_dout !== 8'h11 || f_count !== 4'd2) begin n_fail++; $display("FAIL fwft_head got %h/%0d want 11/2", f_dout, f_count); end
    @(posedge clk); #1;
    f_rd = 1'b0;
    n_checks++; if (f_dout !== 8'h22 || f_dv !== 1'b1) begin n_fail++; $display("FAIL fwft_next got %h/%b want 22/1", f_dout, f_dv); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) drive(1, 1, 0, 8'h50 + 8'(i));
    n_checks++; if (count !== 4'd5) begin n_fail++; $display("FAIL mid_pre_count got %0d want 5", count); end
    drive(1, 0, 1, 8'h00);
    do_reset();
    n_checks++; if (count !== 4'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL mid_count got %0d/%b want 0/1", count, empty); end
    n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL mid_dout got %h want 00", data_out); end
    n_checks++; if ({data_valid, overflow, underflow} !== 3'b000) begin
      n_fail++; $display("FAIL mid_pulses got %b want 000", {data_valid, overflow, underflow});
    end
    drive(1, 0, 1, 8'h00);
    n_checks++; if (data_valid !== 1'b0 || underflow !== 1'b1 || data_out !== 8'h00) begin
      n_fail++; $display("FAIL mid_stale got dv=%b unf=%b dout=%h want 0/1/00", data_valid, underflow, data_out);
    end
    drive(1, 1, 0, 8'h77);
    drive(1, 0, 1, 8'h00);
    n_checks++; if (data_out !== 8'h77 || data_valid !== 1'b1) begin n_fail++; $display("FAIL mid_fresh got %h/%b want 77/1", data_out, data_valid); end
  endtask

  task automatic test_chip_select();
    drive(1, 1, 0, 8'h61);
    drive(1, 1, 0, 8'h62);
    for (int i = 0; i < 6; i++) begin
      drive(0, i[0], i[1] | i[2], 8'hC0 + 8'(i));
      n_checks++; if (count !== 4'd2) begin n_fail++; $display("FAIL cs_count i=%0d got %0d want 2", i, count); end
      n_checks++; if ({data_valid, overflow, underflow} !== 3'b000) begin
        n_fail++; $display("FAIL cs_pulses i=%0d got %b want 000", i, {data_valid, overflow, underflow});
      end
    end
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 1, 8'h00);
      n_checks++; if (data_out !== m_exp) begin n_fail++; $display("FAIL cs_drain i=%0d got %h want %h", i, data_out, m_exp); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow_underflow();
    test_simul_full();
    test_wrap();
    test_fwft();
    test_reset_mid();
    test_chip_select();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
